// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_meter
// Purpose  : Synchronises a slow square wave into the clk domain and measures
//            every half-period in clk cycles. Each measurement is offered on a
//            valid/ready interface together with the level of the phase that
//            just ended and a tolerance flag against the nominal half-period.
//            A stalled input and dropped measurements are also flagged.
// Ports    : clk         system clock
//            reset       synchronous, active-high
//            sig_in      asynchronous slow square wave to measure
//            meas_ready  consumer accepts the current result
//            clr_flags   clears the sticky overrun flag
//            meas_valid  result fields hold an unconsumed measurement
//            meas_cnt    half-period length in clk cycles
//            meas_level  level of the measured half (1 = high, 0 = low)
//            meas_in_tol |meas_cnt - EXPECTED_HALF| <= TOL
//            stalled     no edge seen for TIMEOUT cycles (level)
//            overrun     sticky: a measurement was dropped
// Revision : 1.0 - initial release
// ============================================================================
module clk_period_meter #(
  parameter int CNT_W         = 32,
  parameter int EXPECTED_HALF = 25000000,
  parameter int TOL           = 1000,
  parameter int TIMEOUT       = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             meas_ready,
  input  logic             clr_flags,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_level,
  output logic             meas_in_tol,
  output logic             stalled,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] c_expected = CNT_W'(EXPECTED_HALF);
  localparam logic [CNT_W-1:0] c_tol      = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_WAIT_EDGE = 1'b0,
    ST_MEASURE   = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;

  logic             w_edge;
  logic [CNT_W-1:0] w_diff;
  logic             w_in_tol;
  logic             w_xfer;

  // r_s1/r_s2 form the synchroniser; r_s3 only remembers the previous
  // synchronised level so any change of r_s2 is one edge.
  assign w_edge = r_s2 ^ r_s3;

  // Unsigned absolute difference: subtract the smaller from the larger so
  // the result can never wrap.
  assign w_diff   = (r_cnt >= c_expected) ? (r_cnt - c_expected)
                                          : (c_expected - r_cnt);
  assign w_in_tol = (w_diff <= c_tol);

  assign w_xfer = meas_valid & meas_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WAIT_EDGE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      meas_valid  <= 1'b0;
      meas_cnt    <= '0;
      meas_level  <= 1'b0;
      meas_in_tol <= 1'b0;
      stalled     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      // Clear first so that a drop later in this block overrides it.
      if (clr_flags) begin
        overrun <= 1'b0;
      end

      // A consumed result empties the output; a capture below may refill it
      // in the same cycle.
      if (w_xfer) begin
        meas_valid <= 1'b0;
      end

      case (r_state)
        ST_WAIT_EDGE: begin
          r_cnt <= '0;
          if (w_edge) begin
            // Starting edge only: no complete half-period yet.
            r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
            stalled <= 1'b0;
            r_state <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (w_edge) begin
            r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
            stalled <= 1'b0;
            if (!meas_valid || meas_ready) begin
              meas_valid  <= 1'b1;
              meas_cnt    <= r_cnt;
              meas_level  <= ~r_s2;
              meas_in_tol <= w_in_tol;
            end else begin
              // Unconsumed result is kept; the new one is lost.
              overrun <= 1'b1;
            end
          end else if (r_cnt == c_timeout) begin
            stalled <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_WAIT_EDGE;
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_WAIT_EDGE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_period_meter
// Purpose  : Self-checking bench for clk_period_meter. Directed scenarios
//            followed by randomized half-periods, handshake and resets; every
//            output is compared each cycle against a model that works from the
//            sampled history of sig_in and the edge/handshake rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int EXP   = 10;
  localparam int TOLV  = 1;
  localparam int TMO   = 40;
  localparam int MAXC  = 8192;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_in = 1'b0;
  logic             meas_ready = 1'b0;
  logic             clr_flags = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_cnt;
  logic             meas_level;
  logic             meas_in_tol;
  logic             stalled;
  logic             overrun;

  clk_period_meter #(
    .CNT_W         (CNT_W),
    .EXPECTED_HALF (EXP),
    .TOL           (TOLV),
    .TIMEOUT       (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .meas_ready  (meas_ready),
    .clr_flags   (clr_flags),
    .meas_valid  (meas_valid),
    .meas_cnt    (meas_cnt),
    .meas_level  (meas_level),
    .meas_in_tol (meas_in_tol),
    .stalled     (stalled),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Sampled value of sig_in at each posedge, and the posedge of the last reset.
  bit samp [MAXC];
  int cyc      = 0;
  int last_rst = -1;
  bit cur_sig  = 1'b0;

  // Reference model state.
  bit m_armed;
  int m_t0;
  bit m_valid;
  int m_cnt;
  bit m_level;
  bit m_tol;
  bit m_stalled;
  bit m_overrun;

  // Value the synchroniser holds for posedge k; anything at or before a
  // reset reads as 0 because reset clears the flops.
  function automatic bit val(int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return samp[k];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model(bit s, bit r, bit c, bit rs);
    bit e;
    bit xfer;
    int d;
    samp[cyc] = s;
    if (rs) begin
      last_rst  = cyc;
      m_armed   = 0;
      m_t0      = 0;
      m_valid   = 0;
      m_cnt     = 0;
      m_level   = 0;
      m_tol     = 0;
      m_stalled = 0;
      m_overrun = 0;
    end else begin
      // A change sampled at posedge P0 is acted on at posedge P0+2.
      e    = (val(cyc - 2) != val(cyc - 3));
      xfer = m_valid && r;
      if (c) m_overrun = 0;
      if (xfer) m_valid = 0;
      if (e) begin
        if (m_armed) begin
          if (m_valid && !r) begin
            m_overrun = 1;
          end else begin
            m_valid = 1;
            m_cnt   = cyc - m_t0;
            m_level = val(cyc - 3);
            d       = (m_cnt > EXP) ? m_cnt - EXP : EXP - m_cnt;
            m_tol   = (d <= TOLV);
          end
        end
        m_armed   = 1;
        m_t0      = cyc;
        m_stalled = 0;
      end else if (m_armed && (cyc - m_t0 == TMO)) begin
        m_stalled = 1;
        m_armed   = 0;
      end
    end
    cyc++;
  endtask

  task automatic step(bit s, bit r, bit c, bit rs);
    if (cyc >= MAXC) return;
    sig_in     = s;
    meas_ready = r;
    clr_flags  = c;
    reset      = rs;
    @(posedge clk);
    model(s, r, c, rs);
    #1;
    chk("meas_valid", 32'(meas_valid), 32'(m_valid));
    chk("stalled",    32'(stalled),    32'(m_stalled));
    chk("overrun",    32'(overrun),    32'(m_overrun));
    if (m_valid || rs) begin
      chk("meas_cnt",    32'(meas_cnt),    32'(m_cnt));
      chk("meas_level",  32'(meas_level),  32'(m_level));
      chk("meas_in_tol", 32'(meas_in_tol), 32'(m_tol));
    end
  endtask

  // Toggle sig_in, then hold it for len cycles with a fixed ready.
  task automatic seg(int len, bit r);
    cur_sig = ~cur_sig;
    repeat (len) step(cur_sig, r, 1'b0, 1'b0);
  endtask

  initial begin
    int len;
    bit rdy_mode;
    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Regular 10-cycle halves.
    repeat (8) seg(10, 1'b1);

    // Half-periods straddling the tolerance window.
    seg(11, 1'b1);
    seg(12, 1'b1);
    seg(9, 1'b1);
    seg(8, 1'b1);
    seg(10, 1'b1);

    // Consumer stalls across two edges, then drains, then flags cleared.
    seg(10, 1'b0);
    seg(10, 1'b0);
    seg(3, 1'b0);
    step(cur_sig, 1'b1, 1'b0, 1'b0);
    step(cur_sig, 1'b0, 1'b0, 1'b0);
    step(cur_sig, 1'b0, 1'b1, 1'b0);
    step(cur_sig, 1'b0, 1'b0, 1'b0);

    // Transfer and capture on the same posedge.
    seg(10, 1'b0);
    cur_sig = ~cur_sig;
    for (int i = 0; i < 10; i++) step(cur_sig, (i == 2), 1'b0, 1'b0);
    seg(10, 1'b1);

    // Stall, recovery edge, then a real measurement.
    seg(60, 1'b1);
    seg(10, 1'b1);
    seg(10, 1'b1);
    seg(10, 1'b1);

    // Reset in the middle of a half-period.
    seg(10, 1'b1);
    cur_sig = ~cur_sig;
    repeat (4) step(cur_sig, 1'b1, 1'b0, 1'b0);
    step(cur_sig, 1'b1, 1'b0, 1'b1);
    repeat (5) step(cur_sig, 1'b1, 1'b0, 1'b0);
    repeat (3) seg(10, 1'b1);

    // Randomized half-periods, handshake pressure, clears and resets.
    while (cyc < MAXC - 64) begin
      len      = $urandom_range(1, 48);
      rdy_mode = ($urandom_range(0, 3) != 0);
      cur_sig  = ~cur_sig;
      for (int i = 0; i < len; i++) begin
        step(cur_sig,
             rdy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 599) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Receive-side companion to the team's clock divider. It takes a slow square wave, such as a divided clock or an external tick, synchronises it into the clk domain and measures each half-period in clk cycles. Each measurement is reported through a valid/ready interface with a tolerance check against the expected half-period. It also flags a stalled input and dropped measurements. It sits between divider or external-tick outputs and the status/debug logic.

Parameters:
CNT_W, 32, width of all cycle counters and result fields
EXPECTED_HALF, 25000000, nominal half-period in clk cycles
TOL, 1000, allowed absolute deviation from EXPECTED_HALF
TIMEOUT, 50000000, cycles without an edge before the input is declared stalled

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
sig_in  in  1  asynchronous slow square wave to measure
meas_ready  in  1  consumer accepts the current result
clr_flags  in  1  clears the sticky overrun flag
meas_valid  out  1  result fields hold an unconsumed measurement
meas_cnt  out  CNT_W  half-period length in clk cycles
meas_level  out  1  level of the measured half: 1 = high phase, 0 = low phase
meas_in_tol  out  1  |meas_cnt - EXPECTED_HALF| <= TOL
stalled  out  1  no edge seen for TIMEOUT cycles
overrun  out  1  sticky: a measurement was dropped

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - Synchroniser flops are 0.
  - Counter is 0.
  - State is WAIT_EDGE.
- Synchroniser and edge detect:
  - sig_in passes through 2 flops (s1, s2), plus a history flop s3.
  - edge = s2 ^ s3. A rising edge has s2=1; a falling edge has s2=0.
  - Glitches shorter than 1 clk are not guaranteed to be seen.
- Counter cnt:
  - On an edge cycle, cnt is reloaded to 1; otherwise it increments.
  - cnt saturates at all-ones and never wraps.
  - Consequence: for edges detected at cycles t0 and t1, the value of cnt at t1 is t1 - t0.
- States:
  - WAIT_EDGE: cnt is held at 0, no timeout checking. On edge -> MEASURE (cnt=1), stalled <= 0. This first edge produces no result.
  - MEASURE, on edge:
    - Capture cnt into meas_cnt.
    - meas_level <= ~s2 (the level that just ended).
    - meas_in_tol is computed with an unsigned absolute difference, no overflow.
    - meas_valid <= 1.
    - Stay in MEASURE.
  - MEASURE, no edge and cnt == TIMEOUT: stalled <= 1, go to WAIT_EDGE.
- Latency: if sig_in is first sampled at its new value on posedge P0 (into s1), the edge is detected in the cycle after P1, and meas_valid and the result fields update on P2.
- Handshake:
  - A transfer occurs on a posedge where meas_valid && meas_ready.
  - Result fields are stable while meas_valid=1 and not yet consumed.
  - Transfer with no capture on the same cycle: meas_valid <= 0.
  - Transfer and capture on the same cycle: the new result is loaded and meas_valid stays 1. This is not an overrun.
  - Capture while meas_valid=1 and meas_ready=0: the new measurement is dropped, the old result is held, overrun <= 1.
- overrun:
  - Sticky until clr_flags=1.
  - If clr_flags and a new drop occur on the same cycle, the drop wins (overrun=1).
- stalled:
  - Is a level, not a pulse.
  - Clears on the next detected edge.
  - A stalled transition does not alter meas_valid or the held result.
- Reset mid-measurement: all state is discarded. The next edge after reset is treated as the first edge and yields no result.

Test Plan:
All scenarios use CNT_W=16, EXPECTED_HALF=10, TOL=1, TIMEOUT=40.
1. sig_in toggles every 10 clk, meas_ready=1 -> first edge yields no result; every later edge gives meas_cnt=10, meas_in_tol=1, meas_level alternating 1/0; meas_valid is a 1-cycle pulse 2 posedges after sig_in is sampled changed.
2. Half-periods of 11, 12, 9 and 8 cycles -> meas_cnt=11/12/9/8 with meas_in_tol=1/0/1/0 respectively.
3. meas_ready=0 across two edges -> the first result is held unchanged, the second is dropped, overrun=1. Then meas_ready=1 -> one transfer, meas_valid=0. clr_flags=1 -> overrun=0.
4. meas_valid=1 and meas_ready=1 on the capture cycle -> the new value is loaded, meas_valid stays 1, overrun stays 0.
5. sig_in held constant after an edge -> stalled=1 exactly 40 cycles after that edge's detection. Next edge -> stalled=0 and no result. The following edge yields a valid result.
6. reset asserted for 1 cycle mid-half-period -> all outputs are 0. The first post-reset edge gives no result; the second edge gives the correct meas_cnt.
